// File: rtl/bcd2bin_seq_pkg.sv
// Shared encodings and constants for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] ADJ_TH  = 4'd8;
   localparam logic [3:0] ADJ_SUB = 4'd3;

endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// One BCD digit correction for reverse double-dabble: digits that picked up
// a shifted-in 8 from the digit above are pulled back by 3.
module bcd_digit_adj
   import bcd2bin_seq_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   assign o_nib = (i_nib >= ADJ_TH) ? (i_nib - ADJ_SUB) : i_nib;

endmodule

// File: rtl/bcd2bin_seq.sv
// Multi-cycle BCD-to-binary converter: one shift/adjust step per clock,
// start/busy/done handshake, flags non-BCD digits without converting.
module bcd2bin_seq
   import bcd2bin_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [4*DIGITS-1:0]   i_bcd_in,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [BIN_W-1:0]      o_bin_out
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   state_t                    r_state;
   logic [BCD_W-1:0]          r_bcd;
   logic [BIN_W-1:0]          r_bin;
   logic [CNT_W-1:0]          r_cnt;

   logic [BCD_W+BIN_W-1:0]    w_shift;
   logic [BCD_W-1:0]          w_bcd_sh;
   logic [BCD_W-1:0]          w_bcd_adj;
   logic [BIN_W-1:0]          w_bin_sh;
   logic [DIGITS-1:0]         w_nib_bad;
   logic                      w_last;

   // The LSB of the BCD register falls into the binary register each step.
   assign w_shift  = {r_bcd, r_bin} >> 1;
   assign w_bcd_sh = w_shift[BCD_W+BIN_W-1:BIN_W];
   assign w_bin_sh = w_shift[BIN_W-1:0];
   assign w_last   = (r_cnt == CNT_W'(BIN_W - 1));

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_dig
         bcd_digit_adj u_adj (
            .i_nib (w_bcd_sh[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
         );
         assign w_nib_bad[g] = (i_bcd_in[4*g +: 4] > BCD_MAX);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_bcd     <= '0;
         r_bin     <= '0;
         r_cnt     <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         o_bin_out <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_bcd  <= i_bcd_in;
                  r_bin  <= '0;
                  r_cnt  <= '0;
                  o_busy <= 1'b1;
                  if (|w_nib_bad) begin
                     o_err     <= 1'b1;
                     o_bin_out <= '0;
                     o_done    <= 1'b1;
                     r_state   <= ST_DONE;
                  end else begin
                     o_err   <= 1'b0;
                     r_state <= ST_CONV;
                  end
               end
            end
            ST_CONV: begin
               r_bcd <= w_bcd_adj;
               r_bin <= w_bin_sh;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  o_bin_out <= w_bin_sh;
                  o_done    <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized and directed check of bcd2bin_seq against a cycle-count model.
module tb_bcd2bin_seq;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_start = 1'b0;
   logic [11:0]       i_bcd_in = '0;
   logic              o_busy, o_done, o_err;
   logic [BIN_W-1:0]  o_bin_out;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_start   (i_start),
      .i_bcd_in  (i_bcd_in),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_err     (o_err),
      .o_bin_out (o_bin_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit is_bad(input logic [11:0] b);
      return (b[3:0] > 4'd9) || (b[7:4] > 4'd9) || (b[11:8] > 4'd9);
   endfunction

   function automatic int dec_val(input logic [11:0] b);
      return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]);
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'((v) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   // Model: a request becomes a result BIN_W edges later, or at once if malformed.
   logic m_busy = 0, m_done = 0, m_err = 0;
   int   m_bin = 0, m_pend = 0, m_cnt = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 0; m_done <= 0; m_err <= 0; m_bin <= 0; m_cnt <= 0;
      end else if (m_done) begin
         m_done <= 0; m_busy <= 0;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_done <= 1; m_bin <= m_pend;
         end
      end else if (i_start) begin
         m_busy <= 1;
         if (is_bad(i_bcd_in)) begin
            m_err <= 1; m_bin <= 0; m_done <= 1;
         end else begin
            m_err <= 0; m_pend <= dec_val(i_bcd_in); m_cnt <= BIN_W;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", int'(o_busy), int'(m_busy));
         chk("done", int'(o_done), int'(m_done));
         if (m_done || !m_busy) begin
            chk("err", int'(o_err), int'(m_err));
            chk("bin_out", int'(o_bin_out), m_bin);
         end
      end
   end

   task automatic run_one(input logic [11:0] b, output int lat,
                          output int bin, output int err);
      @(negedge clk);
      i_bcd_in = b; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0; lat = 1;
      while (!o_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      bin = int'(o_bin_out); err = int'(o_err);
   endtask

   int lat, bin, err, wd;

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_err", int'(o_err), 0);
      chk("rst_bin", int'(o_bin_out), 0);
      rst = 1'b1;
      chk_en = 1'b1;

      run_one(12'h999, lat, bin, err);
      chk("lat_999", lat, 11); chk("bin_999", bin, 999); chk("err_999", err, 0);
      run_one(12'h000, lat, bin, err);
      chk("bin_000", bin, 0); chk("err_000", err, 0);
      run_one(12'h255, lat, bin, err);
      chk("bin_255", bin, 255);
      run_one(12'h1A3, lat, bin, err);
      chk("lat_1A3", lat, 1); chk("err_1A3", err, 1); chk("bin_1A3", bin, 0);

      // Second start while converting must be ignored.
      @(negedge clk);
      i_bcd_in = 12'h042; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (2) @(negedge clk);
      i_bcd_in = 12'h111; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0; wd = 0;
      while (!o_done && wd < 40) begin @(negedge clk); wd++; end
      chk("bin_042", int'(o_bin_out), 42); chk("err_042", int'(o_err), 0);
      @(negedge clk);
      chk("no_requeue", int'(o_busy), 0);

      // Abort mid-conversion.
      @(negedge clk);
      i_bcd_in = 12'h123; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_done", int'(o_done), 0);
      chk("abort_err", int'(o_err), 0);
      chk("abort_bin", int'(o_bin_out), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_one(12'h007, lat, bin, err);
      chk("bin_007", bin, 7); chk("lat_007", lat, 11);

      // Exhaustive back-to-back sweep with start held high.
      @(negedge clk);
      i_bcd_in = to_bcd(0); i_start = 1'b1;
      for (int v = 0; v < 1000; v++) begin
         wd = 0;
         @(negedge clk);
         while (!o_done && wd < 40) begin @(negedge clk); wd++; end
         chk("sweep", int'(o_bin_out), v);
         if (v < 999) i_bcd_in = to_bcd(v + 1);
         else i_start = 1'b0;
      end

      // Random traffic, including malformed digits and starts while busy.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         i_start = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) i_bcd_in = to_bcd(int'($urandom_range(0, 999)));
         else i_bcd_in = 12'($urandom);
      end
      i_start = 1'b0;
      repeat (15) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
